mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning the memory read latency in cycles from the enable cycle to data (legal range 1..4).
REQ-002 SHALL have parameter AW, default 32, meaning the address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port i_req, input, 1, instruction-fetch request.
REQ-006 SHALL have port i_addr, input, AW, fetch address.
REQ-007 SHALL have port i_gnt, output, 1, fetch request accepted.
REQ-008 SHALL have port i_rvalid, output, 1, fetch data valid.
REQ-009 SHALL have port i_rdata, output, 32, fetch data.
REQ-010 SHALL have port d_req, input, 1, data load/store request.
REQ-011 SHALL have port d_addr, input, AW, data address.
REQ-012 SHALL have port d_wr, input, 1, store when 1, load when 0.
REQ-013 SHALL have port d_wdata, input, 32, store data.
REQ-014 SHALL have port d_gnt, output, 1, data request accepted.
REQ-015 SHALL have port d_rvalid, output, 1, load data valid or store complete.
REQ-016 SHALL have port d_rdata, output, 32, load data.
REQ-017 SHALL have port m_en, output, 1, memory access strobe.
REQ-018 SHALL have port m_addr, output, AW, memory address.
REQ-019 SHALL have port m_wr, output, 1, memory write enable.
REQ-020 SHALL have port m_wdata, output, 32, memory write data.
REQ-021 SHALL have port m_rdata, input, 32, memory read data, valid MEM_LAT cycles after the m_en cycle.

Function
REQ-022 Requesters SHALL hold req, addr, wr and wdata stable until gnt is seen; the arbiter SHALL NOT require req to be deasserted after a grant.
REQ-023 States: IDLE (no outstanding access) and WAIT (one access outstanding, latency counter running).
REQ-024 A grant SHALL be a single-cycle pulse on exactly one of i_gnt/d_gnt, in the same cycle as m_en=1, m_addr=granted addr, m_wr=d_wr&d_gnt, m_wdata=d_wdata.
REQ-025 Arbitration: if one req is pending it SHALL be granted; if both are pending, the port not granted most recently SHALL be granted (2-way round robin).
REQ-026 Grant SHALL occur in IDLE, or in WAIT during the cycle whose rvalid is asserted; this gives 1 access/cycle for MEM_LAT=1 and 1 access per MEM_LAT cycles otherwise.
REQ-027 rvalid for the owner SHALL assert for exactly one cycle, MEM_LAT cycles after the grant cycle; the other port's rvalid SHALL remain 0.
REQ-028 i_rdata/d_rdata SHALL equal m_rdata when the respective rvalid=1, and 0 otherwise.
REQ-029 A store SHALL also produce d_rvalid at grant+MEM_LAT, with d_rdata=0.
REQ-030 At most one access SHALL be outstanding; requests arriving in WAIT SHALL wait without grant.
REQ-031 When no grant occurs, m_en, m_wr, m_addr and m_wdata SHALL be 0.
REQ-032 The latency counter SHALL be ceil(log2(MEM_LAT+1)) bits wide and SHALL NOT wrap.

Reset
REQ-033 While rst=1 all outputs SHALL be 0, state SHALL be IDLE, and the last-granted port SHALL be instruction, so the first conflict after reset goes to data.
REQ-034 Reset during WAIT SHALL discard the outstanding access; no rvalid for that access SHALL ever appear.

Structure
REQ-035 Package mem_arb_pkg SHALL hold owner_e {OWN_I, OWN_D} and state_e {IDLE, WAIT}.
REQ-036 The 2-way round-robin picker SHALL be a sub-module rr_arb2 (inputs: two reqs, last owner; output: owner_e pick, valid).

Verification
REQ-037 MEM_LAT=1: i_req only, i_addr=0x100, m_rdata=0x00000013 -> i_gnt and m_en with m_addr=0x100 in cycle N; i_rvalid=1 with i_rdata=0x13 in N+1.
REQ-038 Both requests asserted in the first cycle after reset -> d_gnt first, i_gnt next, then alternating while both are held.
REQ-039 Store d_addr=0x200, d_wdata=0xDEADBEEF -> m_wr=1, m_wdata=0xDEADBEEF in the grant cycle; d_rvalid=1, d_rdata=0 after MEM_LAT cycles.
REQ-040 MEM_LAT=3 with continuous i_req -> grants spaced 3 cycles apart; no grant while in WAIT except in the rvalid cycle.
REQ-041 rst=1 one cycle after a grant -> outputs 0 next cycle; no rvalid afterwards; next conflict goes to data.
REQ-042 No requests for 10 cycles -> m_en, gnt and rvalid remain 0 throughout.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: port ownership and FSM state.
package mem_arb_pkg;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a conflict the port that did not win last time wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic   req_fetch,
    input  logic   req_data,
    input  owner_e last,
    output owner_e pick,
    output logic   valid
);

    always_comb begin
        valid = req_fetch | req_data;
        pick  = OWN_I;
        if (req_fetch && req_data) begin
            pick = (last == OWN_I) ? OWN_D : OWN_I;
        end else if (req_data) begin
            pick = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one fixed-latency memory,
// keeping at most one access outstanding.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic          d_wr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          m_en,
    output logic [AW-1:0] m_addr,
    output logic          m_wr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata,
    output state_e        state
);

    localparam int            CW    = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAT_C = CW'(MEM_LAT);

    // Handshake: a requester raises req with stable addr/wr/wdata and holds it
    // until it sees its gnt pulse; the response (rvalid) follows exactly MEM_LAT
    // cycles after that grant cycle, with no back-pressure on either side.
    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    owner_e        last_q, last_d;
    owner_e        pick;
    logic          store_q, store_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pick_valid;
    logic          resp;
    logic          grant;

    rr_arb2 u_rr (
        .req_fetch (i_req),
        .req_data  (d_req),
        .last      (last_q),
        .pick      (pick),
        .valid     (pick_valid)
    );

    // The response cycle doubles as a grant slot so MEM_LAT=1 sustains one access per cycle.
    assign resp  = (state_q == WAIT) && (cnt_q == LAT_C);
    assign grant = !rst && pick_valid && ((state_q == IDLE) || resp);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            last_q  <= OWN_I;
            store_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            store_q <= store_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        store_d = store_q;
        cnt_d   = cnt_q;
        if (grant) begin
            state_d = WAIT;
            owner_d = pick;
            last_d  = pick;
            store_d = (pick == OWN_D) && d_wr;
            cnt_d   = CW'(1);
        end else if (resp) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if ((state_q == WAIT) && (cnt_q != LAT_C)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        i_gnt    = grant && (pick == OWN_I);
        d_gnt    = grant && (pick == OWN_D);
        m_en     = grant;
        m_addr   = '0;
        m_wr     = 1'b0;
        m_wdata  = '0;
        if (grant) begin
            m_addr = (pick == OWN_D) ? d_addr : i_addr;
        end
        if (grant && (pick == OWN_D)) begin
            m_wr    = d_wr;
            m_wdata = d_wdata;
        end
        i_rvalid = !rst && resp && (owner_q == OWN_I);
        d_rvalid = !rst && resp && (owner_q == OWN_D);
        i_rdata  = i_rvalid ? m_rdata : '0;
        d_rdata  = (d_rvalid && !store_q) ? m_rdata : '0;
        state    = rst ? IDLE : state_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 and 3) checked every cycle
// against a cycle-count reference model with an expected-response queue.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        i_req[2], d_req[2], d_wr[2];
    logic [31:0] i_addr[2], d_addr[2], d_wdata[2];
    logic        i_gnt[2], i_rvalid[2], d_gnt[2], d_rvalid[2], m_en[2], m_wr[2];
    logic [31:0] i_rdata[2], d_rdata[2], m_addr[2], m_wdata[2], m_rdata[2];
    state_e      st[2];

    mem_arbiter #(.MEM_LAT(1), .AW(32)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_gnt(i_gnt[0]), .i_rvalid(i_rvalid[0]), .i_rdata(i_rdata[0]),
        .d_req(d_req[0]), .d_addr(d_addr[0]), .d_wr(d_wr[0]), .d_wdata(d_wdata[0]),
        .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
        .m_en(m_en[0]), .m_addr(m_addr[0]), .m_wr(m_wr[0]), .m_wdata(m_wdata[0]), .m_rdata(m_rdata[0]),
        .state(st[0])
    );

    mem_arbiter #(.MEM_LAT(3), .AW(32)) dut3 (
        .clk(clk), .rst(rst),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_gnt(i_gnt[1]), .i_rvalid(i_rvalid[1]), .i_rdata(i_rdata[1]),
        .d_req(d_req[1]), .d_addr(d_addr[1]), .d_wr(d_wr[1]), .d_wdata(d_wdata[1]),
        .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
        .m_en(m_en[1]), .m_addr(m_addr[1]), .m_wr(m_wr[1]), .m_wdata(m_wdata[1]), .m_rdata(m_rdata[1]),
        .state(st[1])
    );

    // Memory model: contents are a fixed function of the address; data appears
    // MEM_LAT cycles after m_en and is garbage at every other time.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0000_0013 : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
    endfunction

    logic        en_p0 = 1'b0;
    logic [2:0]  en_p1 = '0;
    logic [31:0] ap0;
    logic [31:0] ap1[3];

    always @(posedge clk) begin
        en_p0  <= m_en[0];
        ap0    <= m_addr[0];
        en_p1  <= {en_p1[1:0], m_en[1]};
        ap1[0] <= m_addr[1];
        ap1[1] <= ap1[0];
        ap1[2] <= ap1[1];
    end

    assign m_rdata[0] = en_p0    ? mem_val(ap0)    : 32'hBAD0_BAD0;
    assign m_rdata[1] = en_p1[2] ? mem_val(ap1[2]) : 32'hBAD1_BAD1;

    // Reference model state
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          busy_until = 0;
    bit          last_d  = 1'b0;
    int          exp_due_q[$];
    bit          exp_port_q[$];
    logic [31:0] exp_q[$];
    logic        seen_ignt, seen_dgnt;

    // One clock cycle on instance k: predict, compare at negedge, advance model.
    task automatic tick(input int k, output bit gi, output bit gd);
        int          lat;
        bit          rv_i, rv_d;
        logic [31:0] rd_exp, a_exp, wd_exp;
        state_e      st_exp;
        lat = (k == 0) ? 1 : 3;
        gi = 1'b0; gd = 1'b0; rv_i = 1'b0; rv_d = 1'b0; rd_exp = '0;
        @(negedge clk);
        st_exp = (!rst && exp_due_q.size() > 0) ? WAIT : IDLE;
        if (!rst) begin
            if (cyc >= busy_until) begin
                if (i_req[k] && d_req[k]) begin
                    if (last_d) gi = 1'b1; else gd = 1'b1;
                end else if (i_req[k]) begin
                    gi = 1'b1;
                end else if (d_req[k]) begin
                    gd = 1'b1;
                end
            end
            if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
                if (exp_port_q[0]) rv_d = 1'b1; else rv_i = 1'b1;
                rd_exp = exp_q[0];
                void'(exp_due_q.pop_front());
                void'(exp_port_q.pop_front());
                void'(exp_q.pop_front());
            end
        end
        a_exp  = gi ? i_addr[k] : (gd ? d_addr[k] : 32'h0);
        wd_exp = gd ? d_wdata[k] : 32'h0;

        n_tests++; if (i_gnt[k] !== gi) begin n_fail++; $display("FAIL i_gnt k=%0d cyc=%0d got=%b exp=%b", k, cyc, i_gnt[k], gi); end
        n_tests++; if (d_gnt[k] !== gd) begin n_fail++; $display("FAIL d_gnt k=%0d cyc=%0d got=%b exp=%b", k, cyc, d_gnt[k], gd); end
        n_tests++; if (m_en[k] !== (gi | gd)) begin n_fail++; $display("FAIL m_en k=%0d cyc=%0d got=%b exp=%b", k, cyc, m_en[k], gi | gd); end
        n_tests++; if (m_addr[k] !== a_exp) begin n_fail++; $display("FAIL m_addr k=%0d cyc=%0d got=%h exp=%h", k, cyc, m_addr[k], a_exp); end
        n_tests++; if (m_wr[k] !== (gd & d_wr[k])) begin n_fail++; $display("FAIL m_wr k=%0d cyc=%0d got=%b exp=%b", k, cyc, m_wr[k], gd & d_wr[k]); end
        if (!gi) begin
            n_tests++; if (m_wdata[k] !== wd_exp) begin n_fail++; $display("FAIL m_wdata k=%0d cyc=%0d got=%h exp=%h", k, cyc, m_wdata[k], wd_exp); end
        end
        n_tests++; if (i_rvalid[k] !== rv_i) begin n_fail++; $display("FAIL i_rvalid k=%0d cyc=%0d got=%b exp=%b", k, cyc, i_rvalid[k], rv_i); end
        n_tests++; if (d_rvalid[k] !== rv_d) begin n_fail++; $display("FAIL d_rvalid k=%0d cyc=%0d got=%b exp=%b", k, cyc, d_rvalid[k], rv_d); end
        n_tests++; if (i_rdata[k] !== (rv_i ? rd_exp : 32'h0)) begin n_fail++; $display("FAIL i_rdata k=%0d cyc=%0d got=%h exp=%h", k, cyc, i_rdata[k], rv_i ? rd_exp : 32'h0); end
        n_tests++; if (d_rdata[k] !== (rv_d ? rd_exp : 32'h0)) begin n_fail++; $display("FAIL d_rdata k=%0d cyc=%0d got=%h exp=%h", k, cyc, d_rdata[k], rv_d ? rd_exp : 32'h0); end
        n_tests++; if (st[k] !== st_exp) begin n_fail++; $display("FAIL state k=%0d cyc=%0d got=%0d exp=%0d", k, cyc, st[k], st_exp); end

        if (rst) begin
            exp_due_q.delete(); exp_port_q.delete(); exp_q.delete();
            busy_until = 0;
            last_d = 1'b0;
        end else if (gi || gd) begin
            last_d = gd;
            busy_until = cyc + lat;
            exp_due_q.push_back(cyc + lat);
            exp_port_q.push_back(gd);
            exp_q.push_back(gi ? mem_val(i_addr[k]) : (d_wr[k] ? 32'h0 : mem_val(d_addr[k])));
        end
        seen_ignt = i_gnt[k];
        seen_dgnt = d_gnt[k];
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic clear_inputs();
        for (int j = 0; j < 2; j++) begin
            i_req[j] = 1'b0; i_addr[j] = '0; d_req[j] = 1'b0;
            d_addr[j] = '0; d_wr[j] = 1'b0; d_wdata[j] = '0;
        end
    endtask

    task automatic do_reset(input int k);
        bit gi, gd;
        clear_inputs();
        rst = 1'b1;
        tick(k, gi, gd);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bit gi, gd;
        clear_inputs();
        rst = 1'b1;
        for (int j = 0; j < 2; j++) begin
            i_req[j] = 1'b1; d_req[j] = 1'b1; d_wr[j] = 1'b1;
            i_addr[j] = 32'h40; d_addr[j] = 32'h80; d_wdata[j] = 32'h1234_5678;
        end
        tick(0, gi, gd);
        tick(1, gi, gd);
        clear_inputs();
        tick(0, gi, gd);
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        bit gi, gd;
        do_reset(0);
        i_req[0] = 1'b1; i_addr[0] = 32'h100;
        tick(0, gi, gd);
        n_tests++; if (seen_ignt !== 1'b1) begin n_fail++; $display("FAIL fetch_grant got=%b exp=1", seen_ignt); end
        i_req[0] = 1'b0;
        tick(0, gi, gd);
        tick(0, gi, gd);
    endtask

    task automatic test_conflict();
        bit gi, gd;
        logic [5:0] seq;
        do_reset(0);
        i_req[0] = 1'b1; i_addr[0] = 32'h104;
        d_req[0] = 1'b1; d_addr[0] = 32'h208;
        for (int t = 0; t < 6; t++) begin
            tick(0, gi, gd);
            seq[t] = seen_dgnt;
        end
        n_tests++; if (seq !== 6'b010101) begin n_fail++; $display("FAIL conflict_order got=%b exp=010101", seq); end
        clear_inputs();
        tick(0, gi, gd);
    endtask

    task automatic test_store(input int k);
        bit gi, gd;
        do_reset(k);
        d_req[k] = 1'b1; d_wr[k] = 1'b1; d_addr[k] = 32'h200; d_wdata[k] = 32'hDEAD_BEEF;
        tick(k, gi, gd);
        n_tests++; if (seen_dgnt !== 1'b1) begin n_fail++; $display("FAIL store_grant k=%0d got=%b exp=1", k, seen_dgnt); end
        clear_inputs();
        repeat (4) tick(k, gi, gd);
    endtask

    task automatic test_lat3();
        bit gi, gd;
        int n_gnt;
        do_reset(1);
        i_req[1] = 1'b1; i_addr[1] = 32'h100;
        n_gnt = 0;
        for (int t = 0; t < 10; t++) begin
            tick(1, gi, gd);
            if (seen_ignt) n_gnt++;
        end
        n_tests++; if (n_gnt != 4) begin n_fail++; $display("FAIL lat3_grants got=%0d exp=4", n_gnt); end
        clear_inputs();
        repeat (3) tick(1, gi, gd);
    endtask

    task automatic test_reset_in_wait();
        bit gi, gd;
        do_reset(1);
        d_req[1] = 1'b1; d_addr[1] = 32'h300;
        tick(1, gi, gd);
        clear_inputs();
        rst = 1'b1;
        tick(1, gi, gd);
        rst = 1'b0;
        repeat (5) tick(1, gi, gd);
        i_req[1] = 1'b1; i_addr[1] = 32'h104;
        d_req[1] = 1'b1; d_addr[1] = 32'h308;
        tick(1, gi, gd);
        n_tests++; if (seen_dgnt !== 1'b1) begin n_fail++; $display("FAIL post_reset_conflict got=%b exp=1", seen_dgnt); end
        clear_inputs();
        repeat (4) tick(1, gi, gd);
    endtask

    task automatic test_idle(input int k);
        bit gi, gd;
        do_reset(k);
        repeat (10) tick(k, gi, gd);
    endtask

    task automatic test_random(input int k, input int n);
        bit gi, gd;
        do_reset(k);
        for (int t = 0; t < n; t++) begin
            if (!i_req[k] && $urandom_range(0, 2) == 0) begin
                i_req[k] = 1'b1;
                i_addr[k] = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_req[k] && $urandom_range(0, 2) == 0) begin
                d_req[k] = 1'b1;
                d_addr[k] = $urandom & 32'hFFFF_FFFC;
                d_wr[k] = $urandom_range(0, 1) == 1;
                d_wdata[k] = $urandom;
            end
            rst = ($urandom_range(0, 99) == 0);
            tick(k, gi, gd);
            if (gi) i_req[k] = 1'b0;
            if (gd) d_req[k] = 1'b0;
        end
        rst = 1'b0;
        clear_inputs();
        repeat (4) tick(k, gi, gd);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_fetch();
        test_conflict();
        test_store(0);
        test_store(1);
        test_lat3();
        test_reset_in_wait();
        test_idle(0);
        test_random(0, 300);
        test_random(1, 300);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
